// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO read-port arbiter: FSM encoding and width helpers.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 8;
  localparam int DEF_STARVE_LIM = 16;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W  = idx_width(DEF_NUM_REQ);
  localparam int CNT_W = $clog2(DEF_MAX_BURST + 1);
  localparam int STV_W = idx_width(DEF_STARVE_LIM);

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping modulo NUM_REQ.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx,
  output logic [NUM_REQ-1:0] onehot
);

  // Scan ptr+1 .. ptr+NUM_REQ; the owner at ptr itself is checked last.
  always_comb begin
    found  = 1'b0;
    idx    = {IW{1'b0}};
    onehot = {NUM_REQ{1'b0}};
    for (int off = 1; off <= NUM_REQ; off++) begin
      int  k;
      logic hit;
      k         = (int'(ptr) + off) % NUM_REQ;
      hit       = !found && req[k];
      found     = found | hit;
      onehot[k] = hit;
      idx       = hit ? IW'(k) : idx;
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin, burst-bounded sharing of an async FIFO read port among NUM_REQ consumers.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic                             clk_r,
  input  logic                             rst_r_gen,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               rdy,
  input  logic                             fifo_empty,
  input  logic                             fifo_red_en,
  output logic                             red_enable,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [$clog2(NUM_REQ)-1:0]       gnt_id,
  output logic [NUM_REQ-1:0]               dvalid,
  output logic [$clog2(MAX_BURST+1)-1:0]   burst_cnt,
  output logic                             busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int SW = idx_width(STARVE_LIM);

  arb_state_e         state_r, state_s;
  logic [NUM_REQ-1:0] gnt_r;
  logic [IW-1:0]      gnt_id_r;
  logic [IW-1:0]      ptr_r;
  logic [CW-1:0]      burst_cnt_r;
  logic [SW-1:0]      starve_r;
  logic [NUM_REQ-1:0] dvalid_r;

  logic               pick_found_s;
  logic [IW-1:0]      pick_idx_s;
  logic [NUM_REQ-1:0] pick_onehot_s;
  logic               fire_s;
  logic               last_word_s;
  logic               starve_hit_s;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

  assign fire_s       = fifo_red_en && (state_r == ST_BURST);
  assign last_word_s  = fire_s && (burst_cnt_r == CW'(MAX_BURST - 1));
  assign starve_hit_s = fifo_empty && (starve_r == SW'(STARVE_LIM - 1));

  // FSM state register.
  always_ff @(posedge clk_r or negedge rst_r_gen) begin
    if (!rst_r_gen) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and the combinational read request to the FIFO.
  always_comb begin
    state_s    = state_r;
    red_enable = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s && !fifo_empty) begin
          state_s = ST_BURST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        red_enable = req[gnt_id_r] & rdy[gnt_id_r];
        if (last_word_s || !req[gnt_id_r] || starve_hit_s) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_BURST;
        end
      end
      ST_RELEASE: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Grant, burst/starve counters and round-robin pointer.
  always_ff @(posedge clk_r or negedge rst_r_gen) begin
    if (!rst_r_gen) begin
      gnt_r       <= {NUM_REQ{1'b0}};
      gnt_id_r    <= {IW{1'b0}};
      ptr_r       <= IW'(NUM_REQ - 1);
      burst_cnt_r <= {CW{1'b0}};
      starve_r    <= {SW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (state_s == ST_BURST) begin
            gnt_r       <= pick_onehot_s;
            gnt_id_r    <= pick_idx_s;
            burst_cnt_r <= {CW{1'b0}};
            starve_r    <= {SW{1'b0}};
          end
        end
        ST_BURST: begin
          if (fire_s) begin
            burst_cnt_r <= burst_cnt_r + CW'(1'b1);
          end
          starve_r <= fifo_empty ? (starve_r + SW'(1'b1)) : {SW{1'b0}};
          if (state_s == ST_RELEASE) begin
            gnt_r <= {NUM_REQ{1'b0}};
          end
        end
        ST_RELEASE: begin
          // Releasing owner becomes lowest priority for the next pick.
          ptr_r       <= gnt_id_r;
          burst_cnt_r <= {CW{1'b0}};
          starve_r    <= {SW{1'b0}};
        end
        default: begin
          gnt_r       <= {NUM_REQ{1'b0}};
          burst_cnt_r <= {CW{1'b0}};
          starve_r    <= {SW{1'b0}};
        end
      endcase
    end
  end

  // Route each accepted word to its owner one cycle later, including the final word.
  always_ff @(posedge clk_r or negedge rst_r_gen) begin
    if (!rst_r_gen) begin
      dvalid_r <= {NUM_REQ{1'b0}};
    end else begin
      dvalid_r <= fire_s ? gnt_r : {NUM_REQ{1'b0}};
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign dvalid    = dvalid_r;
  assign burst_cnt = burst_cnt_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a counting FIFO model and hand-computed expectations.
module tb_fifo_rd_arbiter;

  logic       clk_r = 1'b0;
  logic       rst_r_gen;
  logic [3:0] req;
  logic [3:0] rdy;
  logic       fifo_empty;
  logic       fifo_red_en;
  logic       red_enable;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] dvalid;
  logic [3:0] burst_cnt;
  logic       busy;

  int fifo_cnt;
  int n_vec;
  int n_miss;
  int pulses;

  fifo_rd_arbiter #(
    .NUM_REQ    (4),
    .MAX_BURST  (8),
    .STARVE_LIM (16)
  ) dut (
    .clk_r       (clk_r),
    .rst_r_gen   (rst_r_gen),
    .req         (req),
    .rdy         (rdy),
    .fifo_empty  (fifo_empty),
    .fifo_red_en (fifo_red_en),
    .red_enable  (red_enable),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .dvalid      (dvalid),
    .burst_cnt   (burst_cnt),
    .busy        (busy)
  );

  always #5 clk_r = ~clk_r;

  assign fifo_empty  = (fifo_cnt == 0);
  assign fifo_red_en = red_enable & ~fifo_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: FIFO pops what was accepted at the edge; outputs settle before return.
  task automatic cyc();
    logic fire;
    @(negedge clk_r);
    fire = fifo_red_en;
    @(posedge clk_r);
    #1;
    if (fire) fifo_cnt--;
    pulses += $countones(dvalid);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(gnt),        32'h0);
    chk({tag, "_gnt_id"}, 32'(gnt_id),     32'h0);
    chk({tag, "_dvalid"}, 32'(dvalid),     32'h0);
    chk({tag, "_bcnt"},   32'(burst_cnt),  32'h0);
    chk({tag, "_red_en"}, 32'(red_enable), 32'h0);
    chk({tag, "_busy"},   32'(busy),       32'h0);
  endtask

  initial begin
    logic [3:0] own;
    rst_r_gen = 1'b0;
    req       = 4'b0000;
    rdy       = 4'b0000;
    fifo_cnt  = 0;
    n_vec     = 0;
    n_miss    = 0;
    pulses    = 0;

    repeat (2) cyc();
    chk_all_zero("reset");
    rst_r_gen = 1'b1;
    cyc();
    chk("idle_busy", 32'(busy), 32'h0);

    // Rotation: 64 words, four requesters, 8-word bursts, 2 dead cycles between bursts.
    fifo_cnt = 64;
    req      = 4'b1111;
    rdy      = 4'b1111;
    pulses   = 0;
    for (int b = 0; b < 8; b++) begin
      own = 4'b0001 << (b % 4);
      cyc();
      chk("rot_gnt",    32'(gnt),        32'(own));
      chk("rot_gnt_id", 32'(gnt_id),     32'(b % 4));
      chk("rot_bcnt0",  32'(burst_cnt),  32'h0);
      chk("rot_red_en", 32'(red_enable), 32'h1);
      for (int k = 1; k < 8; k++) begin
        cyc();
        chk("rot_bcnt",   32'(burst_cnt), 32'(k));
        chk("rot_dvalid", 32'(dvalid),    32'(own));
      end
      cyc();
      chk("last_gnt",    32'(gnt),        32'h0);
      chk("last_busy",   32'(busy),       32'h1);
      chk("last_dvalid", 32'(dvalid),     32'(own));
      chk("last_bcnt",   32'(burst_cnt),  32'h8);
      chk("last_red_en", 32'(red_enable), 32'h0);
      cyc();
      chk("gap_busy",   32'(busy),   32'h0);
      chk("gap_gnt",    32'(gnt),    32'h0);
      chk("gap_dvalid", 32'(dvalid), 32'h0);
    end
    chk("rot_pulses", 32'(pulses),   32'd64);
    chk("rot_drain",  32'(fifo_cnt), 32'd0);
    repeat (2) cyc();
    chk("empty_idle_busy",   32'(busy),       32'h0);
    chk("empty_idle_red_en", 32'(red_enable), 32'h0);

    // Early release: consumer 2 drops req after 3 accepted reads.
    fifo_cnt = 10;
    req      = 4'b0100;
    pulses   = 0;
    cyc();
    chk("early_gnt",    32'(gnt),    32'h4);
    chk("early_gnt_id", 32'(gnt_id), 32'h2);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("early_bcnt",   32'(burst_cnt), 32'(k));
      chk("early_dvalid", 32'(dvalid),    32'h4);
    end
    req = 4'b0000;
    #1;
    chk("early_red_en_drop", 32'(red_enable), 32'h0);
    cyc();
    chk("early_rel_busy",   32'(busy),      32'h1);
    chk("early_rel_gnt",    32'(gnt),       32'h0);
    chk("early_rel_bcnt",   32'(burst_cnt), 32'h3);
    chk("early_rel_dvalid", 32'(dvalid),    32'h0);
    cyc();
    chk("early_idle_busy", 32'(busy),      32'h0);
    chk("early_idle_bcnt", 32'(burst_cnt), 32'h0);
    chk("early_pulses",    32'(pulses),    32'd3);
    chk("early_fifo_left", 32'(fifo_cnt),  32'd7);

    // Starvation: consumer 1 gets 2 words, then the FIFO stays empty.
    fifo_cnt = 2;
    req      = 4'b0010;
    cyc();
    chk("stv_gnt", 32'(gnt), 32'h2);
    repeat (2) cyc();
    chk("stv_bcnt",   32'(burst_cnt), 32'h2);
    chk("stv_dvalid", 32'(dvalid),    32'h2);
    repeat (15) cyc();
    chk("stv_hold_gnt",    32'(gnt),        32'h2);
    chk("stv_hold_busy",   32'(busy),       32'h1);
    chk("stv_hold_red_en", 32'(red_enable), 32'h1);
    chk("stv_hold_dvalid", 32'(dvalid),     32'h0);
    cyc();
    chk("stv_drop_gnt",  32'(gnt),       32'h0);
    chk("stv_drop_busy", 32'(busy),      32'h1);
    chk("stv_drop_bcnt", 32'(burst_cnt), 32'h2);
    repeat (4) cyc();
    chk("stv_idle_busy",   32'(busy),       32'h0);
    chk("stv_idle_gnt",    32'(gnt),        32'h0);
    chk("stv_idle_red_en", 32'(red_enable), 32'h0);

    // Backpressure: rdy[0] alternates 1,0,1,0.. from the first burst cycle.
    fifo_cnt = 20;
    req      = 4'b0001;
    rdy      = 4'b1111;
    cyc();
    chk("bp_gnt", 32'(gnt), 32'h1);
    for (int j = 0; j < 15; j++) begin
      rdy[0] = (j % 2 == 0);
      #1;
      chk("bp_red_en", 32'(red_enable), 32'((j % 2 == 0) ? 1 : 0));
      cyc();
      chk("bp_bcnt",   32'(burst_cnt), 32'(j / 2 + 1));
      chk("bp_dvalid", 32'(dvalid),    32'((j % 2 == 0) ? 1 : 0));
      if (j < 14) chk("bp_gnt_hold", 32'(gnt), 32'h1);
      else        chk("bp_gnt_rel",  32'(gnt), 32'h0);
    end
    rdy = 4'b1111;
    cyc();
    chk("bp_idle_busy", 32'(busy),     32'h0);
    chk("bp_fifo_left", 32'(fifo_cnt), 32'd12);

    // Reset mid-burst with all requesting, then consumer 0 must win first.
    req = 4'b1111;
    cyc();
    chk("rst_pre_gnt", 32'(gnt), 32'h2);
    repeat (2) cyc();
    chk("rst_pre_dvalid", 32'(dvalid),    32'h2);
    chk("rst_pre_bcnt",   32'(burst_cnt), 32'h2);
    rst_r_gen = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    cyc();
    rst_r_gen = 1'b1;
    cyc();
    chk("rst_after_gnt",    32'(gnt),    32'h1);
    chk("rst_after_gnt_id", 32'(gnt_id), 32'h0);
    cyc();
    chk("rst_after_dvalid", 32'(dvalid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
